// File: rtl/digit_frame_sequencer_pkg.sv
// rtl/digit_frame_sequencer_pkg.sv - shared types and constants for the digit frame sequencer
package digit_frame_pkg;

  localparam int SEG_W       = 7;
  localparam int GLYPH_COLS  = 21;
  localparam int GLYPH_PAGES = 4;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  function automatic int bytes_per_frame(input int num_digits, input int digit_cols,
                                         input int gap_cols);
    return GLYPH_PAGES * num_digits * (digit_cols + gap_cols);
  endfunction

endpackage

// File: rtl/digit_frame_sequencer_if.sv
// rtl/digit_frame_sequencer_if.sv - GDDRAM byte stream toward the display transport
interface digit_frame_sequencer_if;

  logic [7:0] data_out;
  logic       data_valid_out;
  logic       data_ready_in;
  logic       page_start_out;
  logic [1:0] page_out;

  modport master (output data_out, data_valid_out, page_start_out, page_out,
                  input  data_ready_in);
  modport slave  (input  data_out, data_valid_out, page_start_out, page_out,
                  output data_ready_in);

endinterface

// File: rtl/digit_frame_sequencer_cursor.sv
// rtl/digit_frame_sequencer_cursor.sv - column/digit/page walk over one frame
module digit_frame_cursor #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_COLS = 21,
  parameter int GAP_COLS   = 3,
  parameter int PAGES      = 4,
  parameter int CW         = 5,
  parameter int DW         = 3
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [CW-1:0] col_o,
  output logic [DW-1:0] digit_o,
  output logic [1:0]    page_o,
  output logic          last_o
);

  logic [CW-1:0] col_q;
  logic [DW-1:0] digit_q;
  logic [1:0]    page_q;
  logic          col_wrap, digit_wrap;

  assign col_wrap   = (col_q == CW'(DIGIT_COLS + GAP_COLS - 1));
  assign digit_wrap = (digit_q == DW'(NUM_DIGITS - 1));
  assign last_o     = col_wrap && digit_wrap && (page_q == 2'(PAGES - 1));

  assign col_o   = col_q;
  assign digit_o = digit_q;
  assign page_o  = page_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col_q   <= '0;
      digit_q <= '0;
      page_q  <= '0;
    end else if (clear_i) begin
      col_q   <= '0;
      digit_q <= '0;
      page_q  <= '0;
    end else if (advance_i) begin
      if (col_wrap) begin
        col_q <= '0;
        if (digit_wrap) begin
          digit_q <= '0;
          page_q  <= page_q + 2'd1;
        end else begin
          digit_q <= digit_q + DW'(1);
        end
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/digit_frame_sequencer.sv
// rtl/digit_frame_sequencer.sv - walks glyph decoder over a digit row, emits page-ordered bytes
module digit_frame_sequencer
  import digit_frame_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_COLS = GLYPH_COLS,
  parameter int GAP_COLS   = 3,
  parameter int PAGES      = GLYPH_PAGES
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits_segments_in,
  output logic [SEG_W-1:0]            dec_segments_out,
  output logic [4:0]                  dec_index_x_out,
  output logic [1:0]                  dec_index_y_out,
  input  logic [7:0]                  dec_pixels_in,
  digit_frame_sequencer_if.master     stream,
  output logic                        busy_out,
  output logic                        frame_done_out
);

  localparam int CW = $clog2(DIGIT_COLS + GAP_COLS);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                      state_q;
  logic [NUM_DIGITS*SEG_W-1:0] snap_q;
  logic [7:0]                  data_q;
  logic                        valid_q, page_start_q, busy_q, done_q;
  logic [1:0]                  page_q;

  logic [CW-1:0] col;
  logic [DW-1:0] digit;
  logic [1:0]    page;
  logic          last, load, clear;

  assign load  = (state_q == STREAM) && (!valid_q || stream.data_ready_in);
  assign clear = (state_q == IDLE) && start_in;

  digit_frame_cursor #(
    .NUM_DIGITS(NUM_DIGITS), .DIGIT_COLS(DIGIT_COLS), .GAP_COLS(GAP_COLS),
    .PAGES(PAGES), .CW(CW), .DW(DW)
  ) u_cursor (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_i  (clear),
    .advance_i(load && !last),
    .col_o    (col),
    .digit_o  (digit),
    .page_o   (page),
    .last_o   (last)
  );

  // Gap columns are clipped here and zeroed on capture, since the decoder wraps out-of-range x.
  assign dec_segments_out = (state_q == STREAM) ? snap_q[digit*SEG_W +: SEG_W] : '0;
  assign dec_index_y_out  = page;
  assign dec_index_x_out  = (col > CW'(DIGIT_COLS - 1)) ? 5'(DIGIT_COLS - 1) : 5'(col);

  assign stream.data_out       = data_q;
  assign stream.data_valid_out = valid_q;
  assign stream.page_start_out = page_start_q;
  assign stream.page_out       = page_q;
  assign busy_out              = busy_q;
  assign frame_done_out        = done_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      page_start_q <= 1'b0;
      page_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            snap_q  <= digits_segments_in;
            busy_q  <= 1'b1;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            data_q       <= (col < CW'(DIGIT_COLS)) ? dec_pixels_in : 8'h00;
            page_start_q <= (digit == '0) && (col == '0);
            page_q       <= page;
            valid_q      <= 1'b1;
            if (last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (stream.data_ready_in) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_frame_sequencer.sv
// tb/tb_digit_frame_sequencer.sv - scoreboard bench for digit_frame_sequencer with a glyph model
module tb_digit_frame_sequencer;
  import digit_frame_pkg::*;

  localparam int ND = 2, DC = 21, GC = 3, PG = 4;
  localparam int NBYTES = bytes_per_frame(ND, DC, GC);

  logic            clk_in = 1'b0, rst_n_in = 1'b0, start_in = 1'b0;
  logic [ND*7-1:0] digits_segments_in = '0;
  logic [6:0]      dec_segments_out;
  logic [4:0]      dec_index_x_out;
  logic [1:0]      dec_index_y_out;
  logic [7:0]      dec_pixels_in;
  logic            busy_out, frame_done_out;

  int          total = 0, bad = 0;
  logic [10:0] sb[$];

  digit_frame_sequencer_if bus();

  digit_frame_sequencer #(.NUM_DIGITS(ND), .DIGIT_COLS(DC), .GAP_COLS(GC), .PAGES(PG)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .digits_segments_in(digits_segments_in),
    .dec_segments_out  (dec_segments_out),
    .dec_index_x_out   (dec_index_x_out),
    .dec_index_y_out   (dec_index_y_out),
    .dec_pixels_in     (dec_pixels_in),
    .stream            (bus.master),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Stand-in glyph decoder: blank for code 0, otherwise a nonzero byte unique-ish per (seg,x,y).
  function automatic logic [7:0] glyph(input logic [6:0] seg, input int x, input int y);
    if (seg == 7'h00) return 8'h00;
    return ({1'b0, seg} ^ 8'(x * 9) ^ 8'(y << 6)) | 8'h01;
  endfunction

  assign dec_pixels_in = glyph(dec_segments_out, int'(dec_index_x_out), int'(dec_index_y_out));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [ND*7-1:0] snap);
    logic [6:0] s;
    for (int p = 0; p < PG; p++)
      for (int d = 0; d < ND; d++)
        for (int c = 0; c < DC + GC; c++) begin
          s = snap[d*7 +: 7];
          sb.push_back({(d == 0 && c == 0), 2'(p), (c < DC) ? glyph(s, c, p) : 8'h00});
        end
  endtask

  task automatic run_frame(input logic [ND*7-1:0] d, input bit keep_start, input int stall_at,
                           input int stall_len, input bit poke, input int rst_at);
    int nbytes = 0, cyc = 0, first_cyc = -1, last_acc = 0, stall_cnt = 0;
    bit got_done = 0, poked = 0;
    logic [10:0] held = '0, cur, exp;
    @(negedge clk_in);
    start_in = 1'b1;
    digits_segments_in = d;
    bus.data_ready_in = 1'b1;
    sb.delete();
    push_frame(d);
    while (cyc < 2000 && !got_done) begin
      @(negedge clk_in);
      cyc++;
      if (!keep_start) start_in = 1'b0;
      if (cyc == 1) chk("busy_start", 32'(busy_out), 32'd1);
      if (rst_at >= 0 && nbytes == rst_at) begin
        #2 rst_n_in = 1'b0;
        #1;
        chk("rst_data",  32'(bus.data_out), 32'h0);
        chk("rst_valid", 32'(bus.data_valid_out), 32'h0);
        chk("rst_pstart", 32'(bus.page_start_out), 32'h0);
        chk("rst_page",  32'(bus.page_out), 32'h0);
        chk("rst_busy",  32'(busy_out), 32'h0);
        chk("rst_done",  32'(frame_done_out), 32'h0);
        chk("rst_decseg", 32'(dec_segments_out), 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        start_in = 1'b0;
        sb.delete();
        return;
      end
      if (poke && !poked && nbytes == 30) begin
        start_in = 1'b1;
        digits_segments_in = ~d;
        poked = 1;
      end
      cur = {bus.page_start_out, bus.page_out, bus.data_out};
      if (stall_len > 0 && nbytes == stall_at && stall_cnt < stall_len) begin
        bus.data_ready_in = 1'b0;
        if (stall_cnt == 0) held = cur;
        else chk("stall_hold", 32'(cur), 32'(held));
        chk("stall_valid", 32'(bus.data_valid_out), 32'd1);
        stall_cnt++;
      end else begin
        bus.data_ready_in = 1'b1;
      end
      if (first_cyc < 0 && bus.data_valid_out) begin
        first_cyc = cyc;
        chk("latency", 32'(cyc), 32'd2);
      end
      if (bus.data_valid_out && bus.data_ready_in) begin
        if (sb.size() == 0) begin
          chk("extra_byte", 32'(nbytes), 32'(NBYTES));
        end else begin
          exp = sb.pop_front();
          chk("byte", 32'(cur), 32'(exp));
        end
        nbytes++;
        last_acc = cyc;
      end
      if (frame_done_out) begin
        got_done = 1;
        chk("done_after_last", 32'(cyc - last_acc), 32'd1);
        chk("busy_at_done", 32'(busy_out), 32'd0);
      end
    end
    if (!got_done) chk("timeout", 32'd0, 32'd1);
    chk("nbytes", 32'(nbytes), 32'(NBYTES));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    if (stall_len == 0) chk("frame_cycles", 32'(last_acc - first_cyc + 1), 32'(NBYTES));
    if (!keep_start) begin
      @(negedge clk_in);
      chk("done_once", 32'(frame_done_out), 32'd0);
      chk("idle_valid", 32'(bus.data_valid_out), 32'd0);
    end
  endtask

  initial begin
    bus.data_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("init_data",  32'(bus.data_out), 32'h0);
    chk("init_valid", 32'(bus.data_valid_out), 32'h0);
    chk("init_pstart", 32'(bus.page_start_out), 32'h0);
    chk("init_page",  32'(bus.page_out), 32'h0);
    chk("init_busy",  32'(busy_out), 32'h0);
    chk("init_done",  32'(frame_done_out), 32'h0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    run_frame({7'h00, 7'h7F}, 0, -1, 0, 0, -1);
    run_frame({7'h00, 7'h7F}, 0, 10, 5, 0, -1);
    run_frame({7'h5A, 7'h33}, 0, -1, 0, 1, -1);
    run_frame({7'h12, 7'h6D}, 0, -1, 0, 0, 50);
    run_frame({7'h12, 7'h6D}, 0, -1, 0, 0, -1);
    run_frame({7'h41, 7'h7F}, 1, -1, 0, 0, -1);
    run_frame({7'h41, 7'h7F}, 0, -1, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
